// File: rtl/link_pkg.sv
// link_pkg: constants and state types shared by the link responder and the
// link health monitor.
//   PING_MAGIC / PONG_MAGIC : 64-bit single-beat frame payloads
//   rx_state_t              : receive-side frame tracker states
//   tx_state_t              : transmit-side merge arbiter states
package link_pkg;

  localparam logic [63:0] PING_MAGIC = 64'h5145_444D_5049_4E47;
  localparam logic [63:0] PONG_MAGIC = 64'h5145_444D_504F_4E47;

  typedef enum logic {
    RX_FIRST,  // next beat is the first beat of a frame
    RX_FWD     // inside a multi-beat frame being forwarded
  } rx_state_t;

  typedef enum logic {
    TX_IDLE,   // at a frame boundary; pongs may be inserted
    TX_USER    // inside a user frame; pongs are held off
  } tx_state_t;

endpackage

// File: rtl/stream_out_reg.sv
// stream_out_reg: single-stage registered valid/ready output slice.
//   clk, rst_n         : clock, asynchronous active-low reset
//   load               : capture load_data/load_last this cycle (only when free)
//   load_data/last     : beat to present on the output
//   free               : register empty or being drained this cycle
//   data/valid/last    : registered output stream
//   ready              : downstream backpressure
module stream_out_reg #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  free,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  last,
  input  logic                  ready
);

  assign free = !valid || ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      last  <= load_last;
      valid <= 1'b1;
    end else if (free) begin
      // Beat drained (or nothing held): drop valid, keep stale data.
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/link_responder.sv
// link_responder: terminates single-beat ping frames from the link, answers
// each with a pong on the return path, forwards all other frames to the user,
// and merges pongs into user TX traffic only at frame boundaries.
//   clk, rst_n                         : clock, asynchronous active-low reset
//   enable                             : 1 = answer pings, 0 = forward all
//   rx_data/rx_valid/rx_last/rx_ready  : link-side receive stream
//   usr_rx_*                           : forwarded non-ping frames
//   usr_tx_*                           : user transmit stream
//   tx_data/tx_valid/tx_last/tx_ready  : link-side transmit stream (registered)
//   pings_rx, pongs_tx, pongs_dropped,
//   fwd_frames                         : wrapping 32-bit event counters
//   pending_cnt                        : queued, unsent pong requests
module link_responder
  import link_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int MAX_PENDING = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  input  logic [DATA_WIDTH-1:0]            rx_data,
  input  logic                             rx_valid,
  input  logic                             rx_last,
  output logic                             rx_ready,
  output logic [DATA_WIDTH-1:0]            usr_rx_data,
  output logic                             usr_rx_valid,
  output logic                             usr_rx_last,
  input  logic                             usr_rx_ready,
  input  logic [DATA_WIDTH-1:0]            usr_tx_data,
  input  logic                             usr_tx_valid,
  input  logic                             usr_tx_last,
  output logic                             usr_tx_ready,
  output logic [DATA_WIDTH-1:0]            tx_data,
  output logic                             tx_valid,
  output logic                             tx_last,
  input  logic                             tx_ready,
  output logic [31:0]                      pings_rx,
  output logic [31:0]                      pongs_tx,
  output logic [31:0]                      pongs_dropped,
  output logic [31:0]                      fwd_frames,
  output logic [$clog2(MAX_PENDING+1)-1:0] pending_cnt
);

  localparam int                PEND_W   = $clog2(MAX_PENDING + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  rx_state_t rx_state;
  tx_state_t tx_state;

  // ---------------- receive path ----------------
  logic is_ping;
  logic fwd_beat;

  // Only a complete single-beat frame carrying the magic word is a ping.
  assign is_ping = (rx_state == RX_FIRST) && rx_valid && rx_last &&
                   (rx_data == PING_MAGIC) && enable;

  assign usr_rx_data  = rx_data;
  assign usr_rx_last  = rx_last;
  assign usr_rx_valid = rx_valid && !is_ping;
  // Pings are swallowed regardless of user backpressure.
  assign rx_ready     = is_ping || usr_rx_ready;
  assign fwd_beat     = usr_rx_valid && usr_rx_ready;

  // NOTE: reset is asynchronous and active-low; every flop lists negedge rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_FIRST;
    end else if (fwd_beat) begin
      rx_state <= rx_last ? RX_FIRST : RX_FWD;
    end
  end

  // ---------------- transmit path ----------------
  logic                  tx_free;
  logic                  pong_due;
  logic                  load_pong;
  logic                  user_xfer;
  logic                  tx_load;
  logic [DATA_WIDTH-1:0] tx_load_data;
  logic                  tx_load_last;
  logic                  pong_drop;

  // Pongs wait for a frame boundary and are suppressed while disabled.
  assign pong_due  = enable && (tx_state == TX_IDLE) && (pending_cnt != '0);
  assign load_pong = pong_due && tx_free;

  // At a boundary the pong wins; inside a user frame the user owns the slot.
  assign usr_tx_ready = (tx_state == TX_USER) ? tx_free : (tx_free && !pong_due);
  assign user_xfer    = usr_tx_valid && usr_tx_ready;

  assign tx_load      = load_pong || user_xfer;
  assign tx_load_data = load_pong ? PONG_MAGIC : usr_tx_data;
  assign tx_load_last = load_pong ? 1'b1 : usr_tx_last;

  stream_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_tx_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (tx_load),
    .load_data (tx_load_data),
    .load_last (tx_load_last),
    .free      (tx_free),
    .data      (tx_data),
    .valid     (tx_valid),
    .last      (tx_last),
    .ready     (tx_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
    end else begin
      unique case (tx_state)
        TX_IDLE: if (user_xfer && !usr_tx_last) tx_state <= TX_USER;
        TX_USER: if (user_xfer &&  usr_tx_last) tx_state <= TX_IDLE;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- pong request queue depth ----------------
  // A post at full depth is lost unless a pong leaves in the same cycle.
  assign pong_drop = is_ping && !load_pong && (pending_cnt == PEND_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_cnt <= '0;
    end else if (!enable) begin
      pending_cnt <= '0;
    end else if (is_ping && !load_pong && !pong_drop) begin
      pending_cnt <= pending_cnt + 1'b1;
    end else if (load_pong && !is_ping) begin
      pending_cnt <= pending_cnt - 1'b1;
    end
  end

  // ---------------- event counters ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pings_rx      <= '0;
      pongs_tx      <= '0;
      pongs_dropped <= '0;
      fwd_frames    <= '0;
    end else begin
      if (is_ping)             pings_rx      <= pings_rx + 32'd1;
      if (load_pong)           pongs_tx      <= pongs_tx + 32'd1;
      if (pong_drop)           pongs_dropped <= pongs_dropped + 32'd1;
      if (fwd_beat && rx_last) fwd_frames    <= fwd_frames + 32'd1;
    end
  end

endmodule

// File: tb/tb_link_responder.sv
// tb_link_responder: directed, table-driven bench for link_responder.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// (registered) or 1 ns after an input change (combinational).
module tb_link_responder;
  import link_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [63:0] rx_data;
  logic        rx_valid;
  logic        rx_last;
  logic        rx_ready;
  logic [63:0] usr_rx_data;
  logic        usr_rx_valid;
  logic        usr_rx_last;
  logic        usr_rx_ready;
  logic [63:0] usr_tx_data;
  logic        usr_tx_valid;
  logic        usr_tx_last;
  logic        usr_tx_ready;
  logic [63:0] tx_data;
  logic        tx_valid;
  logic        tx_last;
  logic        tx_ready;
  logic [31:0] pings_rx;
  logic [31:0] pongs_tx;
  logic [31:0] pongs_dropped;
  logic [31:0] fwd_frames;
  logic [2:0]  pending_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  link_responder #(.DATA_WIDTH(64), .MAX_PENDING(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_last       (rx_last),
    .rx_ready      (rx_ready),
    .usr_rx_data   (usr_rx_data),
    .usr_rx_valid  (usr_rx_valid),
    .usr_rx_last   (usr_rx_last),
    .usr_rx_ready  (usr_rx_ready),
    .usr_tx_data   (usr_tx_data),
    .usr_tx_valid  (usr_tx_valid),
    .usr_tx_last   (usr_tx_last),
    .usr_tx_ready  (usr_tx_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_last       (tx_last),
    .tx_ready      (tx_ready),
    .pings_rx      (pings_rx),
    .pongs_tx      (pongs_tx),
    .pongs_dropped (pongs_dropped),
    .fwd_frames    (fwd_frames),
    .pending_cnt   (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        en;
    logic        rv;
    logic        rl;
    logic [63:0] rd;
    logic        ur;
    logic        exp_uv;
    logic        exp_rr;
    int          exp_pings;
    int          exp_fwd;
  } rx_vec_t;

  rx_vec_t     vecs[10];
  logic [63:0] beats[4];
  int          pong_seen;

  initial begin
    // en rv rl data ur | uv rr pings fwd   (counters are cumulative from reset)
    vecs[0] = '{1'b1, 1'b0, 1'b0, 64'h0,             1'b1, 1'b0, 1'b1, 0, 0}; // idle
    vecs[1] = '{1'b1, 1'b1, 1'b1, PING_MAGIC,        1'b1, 1'b0, 1'b1, 1, 0}; // ping
    vecs[2] = '{1'b1, 1'b1, 1'b1, PING_MAGIC,        1'b0, 1'b0, 1'b1, 2, 0}; // ping, user busy
    vecs[3] = '{1'b1, 1'b1, 1'b0, PING_MAGIC,        1'b1, 1'b1, 1'b1, 2, 0}; // 3-beat, first=magic
    vecs[4] = '{1'b1, 1'b1, 1'b0, 64'h1111,          1'b0, 1'b1, 1'b0, 2, 0}; // stalled mid beat
    vecs[5] = '{1'b1, 1'b1, 1'b0, 64'h1111,          1'b1, 1'b1, 1'b1, 2, 0}; // mid beat accepted
    vecs[6] = '{1'b1, 1'b1, 1'b1, PING_MAGIC,        1'b1, 1'b1, 1'b1, 2, 1}; // magic as last beat
    vecs[7] = '{1'b1, 1'b1, 1'b1, 64'h1234,          1'b1, 1'b1, 1'b1, 2, 2}; // ordinary single beat
    vecs[8] = '{1'b0, 1'b1, 1'b1, PING_MAGIC,        1'b1, 1'b1, 1'b1, 2, 3}; // ping while disabled
    vecs[9] = '{1'b1, 1'b1, 1'b1, PING_MAGIC,        1'b0, 1'b0, 1'b1, 3, 3}; // ping again
    for (int k = 0; k < 4; k++) beats[k] = 64'hB000_0000_0000_0000 | 64'(k);

    rst_n        = 1'b0;
    enable       = 1'b1;
    rx_data      = '0;
    rx_valid     = 1'b0;
    rx_last      = 1'b0;
    usr_rx_ready = 1'b1;
    usr_tx_data  = '0;
    usr_tx_valid = 1'b0;
    usr_tx_last  = 1'b0;
    tx_ready     = 1'b1;

    // ---- reset values ----
    repeat (2) @(negedge clk);
    check("rst tx_valid", 64'(tx_valid), 64'd0);
    check("rst tx_last", 64'(tx_last), 64'd0);
    check("rst tx_data", tx_data, 64'd0);
    check("rst pending", 64'(pending_cnt), 64'd0);
    check("rst pings_rx", 64'(pings_rx), 64'd0);
    check("rst pongs_tx", 64'(pongs_tx), 64'd0);
    check("rst dropped", 64'(pongs_dropped), 64'd0);
    check("rst fwd", 64'(fwd_frames), 64'd0);
    rst_n = 1'b1;

    // ---- table: RX classification and forwarding ----
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      enable       = vecs[i].en;
      rx_valid     = vecs[i].rv;
      rx_last      = vecs[i].rl;
      rx_data      = vecs[i].rd;
      usr_rx_ready = vecs[i].ur;
      #1;
      check($sformatf("vec%0d usr_rx_valid", i), 64'(usr_rx_valid), 64'(vecs[i].exp_uv));
      check($sformatf("vec%0d rx_ready", i), 64'(rx_ready), 64'(vecs[i].exp_rr));
      if (vecs[i].exp_uv) begin
        check($sformatf("vec%0d usr_rx_data", i), usr_rx_data, vecs[i].rd);
        check($sformatf("vec%0d usr_rx_last", i), 64'(usr_rx_last), 64'(vecs[i].rl));
      end
      @(posedge clk);
      #1;
      check($sformatf("vec%0d pings_rx", i), 64'(pings_rx), 64'(vecs[i].exp_pings));
      check($sformatf("vec%0d fwd_frames", i), 64'(fwd_frames), 64'(vecs[i].exp_fwd));
    end
    @(negedge clk);
    enable       = 1'b1;
    rx_valid     = 1'b0;
    usr_rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("table pongs_tx", 64'(pongs_tx), 64'd3);
    check("table pending", 64'(pending_cnt), 64'd0);
    check("table tx idle", 64'(tx_valid), 64'd0);

    // ---- ping-to-pong latency ----
    rx_valid = 1'b1; rx_last = 1'b1; rx_data = PING_MAGIC;
    #1;
    check("lat usr_rx_valid", 64'(usr_rx_valid), 64'd0);
    check("lat rx_ready", 64'(rx_ready), 64'd1);
    @(negedge clk);
    rx_valid = 1'b0;
    check("lat N+1 pending", 64'(pending_cnt), 64'd1);
    check("lat N+1 tx_valid", 64'(tx_valid), 64'd0);
    @(negedge clk);
    check("lat N+2 tx_valid", 64'(tx_valid), 64'd1);
    check("lat N+2 tx_data", tx_data, PONG_MAGIC);
    check("lat N+2 tx_last", 64'(tx_last), 64'd1);
    check("lat N+2 pending", 64'(pending_cnt), 64'd0);
    @(negedge clk);
    check("lat drained", 64'(tx_valid), 64'd0);
    check("lat pings_rx", 64'(pings_rx), 64'd4);
    check("lat pongs_tx", 64'(pongs_tx), 64'd4);

    // ---- ping during a 4-beat user frame ----
    for (int k = 0; k < 4; k++) begin
      usr_tx_valid = 1'b1;
      usr_tx_data  = beats[k];
      usr_tx_last  = (k == 3);
      rx_valid     = (k == 1);
      rx_last      = 1'b1;
      rx_data      = PING_MAGIC;
      #1;
      check($sformatf("frm beat%0d usr_tx_ready", k), 64'(usr_tx_ready), 64'd1);
      @(negedge clk);
      check($sformatf("frm beat%0d tx_data", k), tx_data, beats[k]);
      check($sformatf("frm beat%0d tx_last", k), 64'(tx_last), 64'(k == 3));
    end
    rx_valid = 1'b0;
    check("frm pending held", 64'(pending_cnt), 64'd1);
    usr_tx_data = 64'hAAAA_AAAA_AAAA_AAAA;
    usr_tx_last = 1'b1;
    #1;
    check("frm boundary usr_tx_ready", 64'(usr_tx_ready), 64'd0);
    @(negedge clk);
    check("frm pong tx_data", tx_data, PONG_MAGIC);
    check("frm pong tx_last", 64'(tx_last), 64'd1);
    #1;
    check("frm after pong usr_tx_ready", 64'(usr_tx_ready), 64'd1);
    @(negedge clk);
    usr_tx_valid = 1'b0;
    check("frm next user beat", tx_data, 64'hAAAA_AAAA_AAAA_AAAA);
    @(negedge clk);
    check("frm drained", 64'(tx_valid), 64'd0);
    check("frm pongs_tx", 64'(pongs_tx), 64'd5);

    // ---- overflow with link stalled ----
    tx_ready     = 1'b0;
    usr_tx_valid = 1'b1;
    usr_tx_data  = 64'h0000_0000_00C0_FFEE;
    usr_tx_last  = 1'b1;
    @(negedge clk);
    usr_tx_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      rx_valid = 1'b1; rx_last = 1'b1; rx_data = PING_MAGIC;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    check("ovf pending", 64'(pending_cnt), 64'd4);
    check("ovf dropped", 64'(pongs_dropped), 64'd2);
    check("ovf tx stalled data", tx_data, 64'h0000_0000_00C0_FFEE);
    check("ovf pings_rx", 64'(pings_rx), 64'd11);
    tx_ready  = 1'b1;
    pong_seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (tx_valid && tx_data == PONG_MAGIC) pong_seen++;
      @(negedge clk);
    end
    check("ovf pongs delivered", 64'(pong_seen), 64'd4);
    check("ovf pongs_tx", 64'(pongs_tx), 64'd9);
    check("ovf pending empty", 64'(pending_cnt), 64'd0);

    // ---- disabled: ping is forwarded, nothing queued ----
    enable   = 1'b0;
    rx_valid = 1'b1; rx_last = 1'b1; rx_data = PING_MAGIC;
    #1;
    check("dis usr_rx_valid", 64'(usr_rx_valid), 64'd1);
    check("dis usr_rx_data", usr_rx_data, PING_MAGIC);
    @(negedge clk);
    rx_valid = 1'b0;
    enable   = 1'b1;
    check("dis pending", 64'(pending_cnt), 64'd0);
    check("dis fwd_frames", 64'(fwd_frames), 64'd4);
    check("dis pings_rx", 64'(pings_rx), 64'd11);

    // ---- async reset with queued pongs and a held beat ----
    tx_ready     = 1'b0;
    usr_tx_valid = 1'b1;
    usr_tx_data  = 64'hDEAD;
    usr_tx_last  = 1'b1;
    @(negedge clk);
    usr_tx_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rx_valid = 1'b1; rx_last = 1'b1; rx_data = PING_MAGIC;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    check("ar pre pending", 64'(pending_cnt), 64'd3);
    check("ar pre tx_valid", 64'(tx_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("ar tx_valid", 64'(tx_valid), 64'd0);
    check("ar tx_data", tx_data, 64'd0);
    check("ar tx_last", 64'(tx_last), 64'd0);
    check("ar pending", 64'(pending_cnt), 64'd0);
    check("ar pings_rx", 64'(pings_rx), 64'd0);
    check("ar pongs_tx", 64'(pongs_tx), 64'd0);
    check("ar dropped", 64'(pongs_dropped), 64'd0);
    check("ar fwd", 64'(fwd_frames), 64'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    tx_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("ar no pong c%0d", c), 64'(tx_valid), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/link_responder.md
# link_responder

Far-end partner of the link health monitor: it terminates ping frames arriving on a comm link and answers each with a pong frame on the return path. All other received frames pass through to the user RX port. Pongs are merged into user TX traffic only at frame boundaries. One instance sits per link, between the PHY/stream adapter and the user datapath, and exports counters for the status register block.

## Interface
- DATA_WIDTH, 64, stream width; must be 64 because magic words are 64-bit.
- MAX_PENDING, 4, maximum number of queued, unsent pong requests.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  1 = answer pings; 0 = forward every frame, send no new pongs.
- rx_data / rx_valid / rx_last  in  64/1/1  link-side receive stream.
- rx_ready  out  1  link-side receive backpressure.
- usr_rx_data / usr_rx_valid / usr_rx_last  out  64/1/1  forwarded non-ping frames.
- usr_rx_ready  in  1  user backpressure.
- usr_tx_data / usr_tx_valid / usr_tx_last  in  64/1/1  user transmit stream.
- usr_tx_ready  out  1  user transmit backpressure.
- tx_data / tx_valid / tx_last  out  64/1/1  link-side transmit stream (registered).
- tx_ready  in  1  link-side transmit backpressure.
- pings_rx, pongs_tx, pongs_dropped, fwd_frames  out  32 each  wrapping event counters.
- pending_cnt  out  $clog2(MAX_PENDING+1)  queued pong requests.

## Operation
- **Handshakes.** A transfer occurs when valid && ready in the same cycle. A valid output holds its data until accepted.
- **RX FSM**, states RX_FIRST (reset) and RX_FWD:
  - is_ping = state RX_FIRST && rx_valid && rx_last && rx_data==PING_MAGIC && enable.
  - is_ping: rx_ready=1, usr_rx_valid=0. The beat is consumed, pings_rx++, and one pong request is posted.
  - Otherwise the RX path is a combinational pass-through: usr_rx_* = rx_*, rx_ready = usr_rx_ready.
  - RX_FIRST → RX_FWD on a forwarded beat with rx_last=0.
  - RX_FWD → RX_FIRST on a forwarded beat with rx_last=1.
  - fwd_frames++ on every forwarded beat with last=1.
  - Multi-beat frames, and ping-magic beats that are not the first beat, are always forwarded.
- **Pending counter.**
  - Posting a request increments pending_cnt; loading a pong into the TX register decrements it.
  - Post and load in the same cycle: net unchanged, request accepted.
  - Post while pending_cnt==MAX_PENDING with no load that cycle: request dropped, pongs_dropped++, pending_cnt stays MAX_PENDING.
  - enable=0: pending_cnt is forced to 0 and no new load is started.
- **TX output register.**
  - free = !tx_valid || tx_ready.
  - When free and nothing is loaded, tx_valid clears.
- **TX FSM**, states TX_IDLE (reset) and TX_USER:
  - TX_IDLE, free, pending_cnt>0: load PONG_MAGIC with tx_last=1, pongs_tx++, usr_tx_ready=0. Pong has priority.
  - TX_IDLE, free, pending_cnt==0: usr_tx_ready=1. On a user transfer, load the beat; if usr_tx_last=0, go to TX_USER.
  - TX_USER: usr_tx_ready=free. Pongs are held off. A user beat with last=1 returns the FSM to TX_IDLE.
  - A user frame is never split by a pong.
- **Counters.** All counters are 32-bit and wrap modulo 2^32.

## Timing
- **Reset values:** tx_valid=0, tx_last=0, tx_data=0, all counters 0, pending_cnt=0, both FSMs in their first state.
- **Ping-to-pong latency:** ping accepted in cycle N → pending_cnt=1 in N+1 → tx_valid=1 with PONG_MAGIC in N+2. This assumes TX_IDLE and free.
- **Forwarding latency:** 0 cycles (combinational pass-through).
- **enable falling:**
  - A pong or user beat already in the TX register stays valid until accepted.
  - A user frame in progress completes.
  - A ping beat presented in the same cycle is forwarded.
- **Async reset mid-frame:** all state is dropped immediately. The partial frame is not completed; upstream must also reset.

## Structure
- Package link_pkg: PING_MAGIC = 64'h5145_444D_5049_4E47 and PONG_MAGIC = 64'h5145_444D_504F_4E47. The link monitor uses these same constants.
- Also in link_pkg: rx_state_t {RX_FIRST, RX_FWD} and tx_state_t {TX_IDLE, TX_USER}.
- One sub-module, stream_out_reg: a single-stage registered valid/ready slice holding data/last, exposing free. It is reusable by the monitor.

## Test plan
- Single-beat PING_MAGIC with rx_last=1, tx_ready=1 → PONG_MAGIC with tx_last=1 two cycles later; pings_rx=1, pongs_tx=1, usr_rx_valid never asserted.
- 3-beat frame whose first beat is PING_MAGIC → all 3 beats forwarded; fwd_frames=1, pings_rx=0, no pong.
- User 4-beat frame in progress, ping arrives during beat 2 → pong appears only after the user beat with last=1.
- tx_ready=0, 6 pings sent back-to-back → pending_cnt=4, pongs_dropped=2; release tx_ready → exactly 4 pongs.
- enable=0, then ping → forwarded to usr_rx; pending_cnt stays 0.
- rst_n asserted while pending_cnt=3 and tx_valid=1 → outputs and counters read 0 immediately; no pong after release.
